// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } pll_state_e;

  localparam int unsigned LOSS_CNT_W = 16;

  // Width able to hold 0 .. max(a,b,c,d)-1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification / staggered domain reset release sequencer.
// Optional lock-loss counter output enabled by defining PLL_LOSS_COUNTER_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned NUM_DOMAINS         = 3,
  parameter int unsigned STAGGER_CYCLES      = 8
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic [NUM_DOMAINS-1:0]             rst_out,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef PLL_LOSS_COUNTER_EN
  ,
  output logic [LOSS_CNT_W-1:0]              loss_cnt
`endif
);

  localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                         LOCK_TIMEOUT_CYCLES, STAGGER_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  localparam logic [NUM_DOMAINS-1:0] ALL_RST   = '1;
  localparam logic [NUM_DOMAINS-1:0] FIRST_REL = ALL_RST << 1;

  logic w_locked_s;

  pll_lock_sync u_lock_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  pll_state_e            r_state, w_state_d;
  logic [CW-1:0]         r_cnt, w_cnt_d;
  logic [CW-1:0]         r_tcnt, w_tcnt_d;
  logic                  r_pll_rst, w_pll_rst_d;
  logic [NUM_DOMAINS-1:0] r_rst_out, w_rst_out_d;
  logic                  r_ready, w_ready_d;
  logic                  r_fault, w_fault_d;
  logic [RW-1:0]         r_retry, w_retry_d;
  logic [RW-1:0]         w_retry_inc;
  logic [NUM_DOMAINS-1:0] w_rst_shift;
  logic                  w_timeout;
`ifdef PLL_LOSS_COUNTER_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt, w_loss_cnt_d;
`endif

  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + 1'b1;
  assign w_rst_shift = r_rst_out << 1;
  assign w_timeout   = (r_tcnt == TIMEOUT_LAST);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_tcnt_d    = r_tcnt;
    w_pll_rst_d = r_pll_rst;
    w_rst_out_d = r_rst_out;
    w_ready_d   = r_ready;
    w_fault_d   = r_fault;
    w_retry_d   = r_retry;
`ifdef PLL_LOSS_COUNTER_EN
    w_loss_cnt_d = r_loss_cnt;
`endif

    case (r_state)
      PLL_RESET: begin
        w_pll_rst_d = 1'b1;
        w_rst_out_d = ALL_RST;
        w_ready_d   = 1'b0;
        w_cnt_d     = r_cnt + 1'b1;
        if (r_cnt == PULSE_LAST) begin
          w_state_d   = WAIT_LOCK;
          w_pll_rst_d = 1'b0;
          w_cnt_d     = '0;
          w_tcnt_d    = '0;
        end
      end

      WAIT_LOCK, STABLE: begin
        w_tcnt_d = r_tcnt + 1'b1;
        // Timeout wins over stable-count completion.
        if (w_timeout) begin
          w_retry_d   = w_retry_inc;
          w_cnt_d     = '0;
          w_pll_rst_d = 1'b1;
          if (w_retry_inc == RETRY_MAX) begin
            w_state_d = FAULT;
            w_fault_d = 1'b1;
          end else begin
            w_state_d = PLL_RESET;
          end
        end else if (r_state == WAIT_LOCK) begin
          if (w_locked_s) begin
            w_state_d = STABLE;
            w_cnt_d   = '0;
          end
        end else if (!w_locked_s) begin
          w_state_d = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_cnt_d     = '0;
          w_rst_out_d = FIRST_REL;
          if (FIRST_REL == '0) begin
            w_state_d = RUN;
            w_ready_d = 1'b1;
          end else begin
            w_state_d = RELEASE;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      RELEASE: begin
        if (!w_locked_s) begin
          w_state_d   = PLL_RESET;
          w_rst_out_d = ALL_RST;
          w_pll_rst_d = 1'b1;
          w_cnt_d     = '0;
        end else if (r_cnt == STAGGER_LAST) begin
          w_cnt_d     = '0;
          w_rst_out_d = w_rst_shift;
          if (w_rst_shift == '0) begin
            w_state_d = RUN;
            w_ready_d = 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      RUN: begin
        if (!w_locked_s || relock_req) begin
          w_state_d   = PLL_RESET;
          w_ready_d   = 1'b0;
          w_rst_out_d = ALL_RST;
          w_pll_rst_d = 1'b1;
          w_retry_d   = '0;
          w_cnt_d     = '0;
`ifdef PLL_LOSS_COUNTER_EN
          if (!w_locked_s && (r_loss_cnt != '1)) w_loss_cnt_d = r_loss_cnt + 1'b1;
`endif
        end
      end

      FAULT: begin
        if (relock_req) begin
          w_state_d = PLL_RESET;
          w_fault_d = 1'b0;
          w_retry_d = '0;
          w_cnt_d   = '0;
        end
      end

      default: begin
        w_state_d   = PLL_RESET;
        w_pll_rst_d = 1'b1;
        w_rst_out_d = ALL_RST;
        w_ready_d   = 1'b0;
        w_fault_d   = 1'b0;
        w_cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= PLL_RESET;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_pll_rst <= 1'b1;
      r_rst_out <= ALL_RST;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_retry   <= '0;
`ifdef PLL_LOSS_COUNTER_EN
      r_loss_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_tcnt    <= w_tcnt_d;
      r_pll_rst <= w_pll_rst_d;
      r_rst_out <= w_rst_out_d;
      r_ready   <= w_ready_d;
      r_fault   <= w_fault_d;
      r_retry   <= w_retry_d;
`ifdef PLL_LOSS_COUNTER_EN
      r_loss_cnt <= w_loss_cnt_d;
`endif
    end
  end

  assign pll_rst   = r_pll_rst;
  assign rst_out   = r_rst_out;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
`ifdef PLL_LOSS_COUNTER_EN
  assign loss_cnt  = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/relock traffic,
// all checked every cycle against a timeline-based reference model.
module tb_pll_reset_sequencer;

  localparam int unsigned RP   = 4;
  localparam int unsigned LS   = 8;
  localparam int unsigned LT   = 32;
  localparam int unsigned MR   = 2;
  localparam int unsigned NDOM = 3;
  localparam int unsigned SG   = 2;

  localparam int PH_PULSE = 0;
  localparam int PH_ACQ   = 1;
  localparam int PH_REL   = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FLT   = 4;

  logic            refclk = 1'b0;
  logic            rst;
  logic            pll_locked;
  logic            relock_req;
  logic            pll_rst;
  logic [NDOM-1:0] rst_out;
  logic            ready;
  logic            fault;
  logic [1:0]      retry_cnt;
`ifdef PLL_LOSS_COUNTER_EN
  logic [15:0]     loss_cnt;
`endif

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (LT),
    .MAX_RETRIES         (MR),
    .NUM_DOMAINS         (NDOM),
    .STAGGER_CYCLES      (SG)
  ) u_dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .rst_out    (rst_out),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
`ifdef PLL_LOSS_COUNTER_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: phase timeline, elapsed time, consecutive-high run length.
  int   m_ph, m_t, m_run, m_ret, m_loss;
  logic h1, h2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic m_reset();
    m_ph = PH_PULSE; m_t = 0; m_run = 0; m_ret = 0; m_loss = 0;
    h1 = 1'b0; h2 = 1'b0;
  endtask

  task automatic m_edge(input logic ls, input logic rq);
    case (m_ph)
      PH_PULSE: begin
        m_t++;
        if (m_t == RP) begin m_ph = PH_ACQ; m_t = 0; m_run = 0; end
      end
      PH_ACQ: begin
        m_t++;
        m_run = ls ? m_run + 1 : 0;
        if (m_t == LT) begin
          if (m_ret < MR) m_ret++;
          m_ph = (m_ret == MR) ? PH_FLT : PH_PULSE;
          m_t  = 0;
        end else if (m_run == LS + 1) begin
          // First high moves to qualification, then LS more consecutive highs.
          m_ph = PH_REL; m_t = 0;
        end
      end
      PH_REL: begin
        if (!ls) begin m_ph = PH_PULSE; m_t = 0; end
        else begin
          m_t++;
          if (1 + m_t / SG >= NDOM) m_ph = PH_RUN;
        end
      end
      PH_RUN: begin
        if (!ls || rq) begin
          if (!ls && m_loss < 65535) m_loss++;
          m_ret = 0; m_ph = PH_PULSE; m_t = 0;
        end
      end
      default: begin
        if (rq) begin m_ret = 0; m_ph = PH_PULSE; m_t = 0; end
      end
    endcase
  endtask

  task automatic check_model();
    logic [NDOM-1:0] e_rst;
    e_rst = '1;
    if (m_ph == PH_RUN) e_rst = '0;
    else if (m_ph == PH_REL) e_rst = e_rst << (1 + m_t / SG);
    chk("pll_rst", 32'(pll_rst), 32'(m_ph == PH_PULSE || m_ph == PH_FLT));
    chk("rst_out", 32'(rst_out), 32'(e_rst));
    chk("ready", 32'(ready), 32'(m_ph == PH_RUN));
    chk("fault", 32'(fault), 32'(m_ph == PH_FLT));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_ret));
`ifdef PLL_LOSS_COUNTER_EN
    chk("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
  endtask

  task automatic step();
    logic ls;
    @(posedge refclk);
    ls = h2; h2 = h1; h1 = pll_locked;
    m_edge(ls, relock_req);
    cyc++;
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_rst_out"}, 32'(rst_out), 32'h7);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    m_reset();
    #7;
    check_reset_vals("reset");
    rst = 1'b0;

    // Clean bring-up: lock sampled at edge 10.
    while (cyc < 30) begin
      if (cyc == 9) pll_locked = 1'b1;
      step();
      if (cyc == 3)  chk("bringup_pll_rst_hi", 32'(pll_rst), 32'd1);
      if (cyc == 4)  chk("bringup_pll_rst_lo", 32'(pll_rst), 32'd0);
      if (cyc == 19) chk("bringup_rst19", 32'(rst_out), 32'h7);
      if (cyc == 20) chk("bringup_rst20", 32'(rst_out), 32'h6);
      if (cyc == 22) chk("bringup_rst22", 32'(rst_out), 32'h4);
      if (cyc == 23) chk("bringup_ready23", 32'(ready), 32'd0);
      if (cyc == 24) begin
        chk("bringup_rst24", 32'(rst_out), 32'h0);
        chk("bringup_ready24", 32'(ready), 32'd1);
      end
    end

    // Lock loss in RUN, then lock never returns.
    pll_locked = 1'b0;
    step(); chk("loss_hold1", 32'(ready), 32'd1);
    step(); chk("loss_hold2", 32'(ready), 32'd1);
    step();
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("loss_rst_out", 32'(rst_out), 32'h7);
    repeat (100) step();
    chk("never_fault", 32'(fault), 32'd1);
    chk("never_retry", 32'(retry_cnt), 32'd2);
    chk("never_rst_out", 32'(rst_out), 32'h7);
`ifdef PLL_LOSS_COUNTER_EN
    chk("never_loss_cnt", 32'(loss_cnt), 32'd1);
`endif

    // Relock out of FAULT, ignored relock during acquisition, glitchy lock.
    relock_req = 1'b1; step(); relock_req = 1'b0;
    chk("relock_fault", 32'(fault), 32'd0);
    chk("relock_retry", 32'(retry_cnt), 32'd0);
    repeat (5) step();
    relock_req = 1'b1; step(); relock_req = 1'b0;
    chk("relock_ignored_pll_rst", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1; repeat (5) step();
    pll_locked = 1'b0; step();
    pll_locked = 1'b1; repeat (20) step();
    chk("glitch_ready", 32'(ready), 32'd1);
    chk("glitch_retry", 32'(retry_cnt), 32'd0);

    // Relock from RUN, then async reset between first and second release.
    relock_req = 1'b1; step(); relock_req = 1'b0;
    for (int i = 0; i < 100 && rst_out != 3'b110; i++) step();
    chk("mid_release_reach", 32'(rst_out), 32'h6);
    #2 rst = 1'b1;
    m_reset();
    #1 check_reset_vals("async");
    #3 rst = 1'b0;

    // Random lock segments with occasional relock requests.
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      pll_locked = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
      for (int i = 0; i < len; i++) begin
        relock_req = ($urandom_range(0, 31) == 0);
        step();
      end
      relock_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
